// File: rtl/mskaes_ct_serializer.sv
// Serializes a d-share masked 128-bit AES ciphertext block into four 32-bit
// masked words; shares pass through untouched and the holding register is zeroized.
module mskaes_ct_serializer #(
  parameter int d = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [128*d-1:0]  sh_block_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*d-1:0]   sh_word_out,
  output logic              out_last,
  output logic              busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       r_state;
  logic [1:0]       r_cnt;
  logic [128*d-1:0] r_hold;

  logic             w_last_word;
  logic             w_accept;
  logic             w_out_hs;
  logic [32*d-1:0]  w_word;

  assign w_last_word = (r_cnt == 2'd3);
  assign out_valid   = (r_state == SEND);
  assign busy        = out_valid;
  assign out_last    = out_valid && w_last_word;

  // A new block may replace the current one on the cycle its last word leaves.
  assign in_ready    = (r_state == IDLE) || (w_last_word && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;

  assign w_word      = r_hold[32*d*r_cnt +: 32*d];
  assign sh_word_out = out_valid ? w_word : '0;

  // NOTE: r_hold is a data register but still gets reset: it carries secret
  // shares and must read as zero from the instant reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_hold  <= '0;
    end else if (w_accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state <= SEND;
      r_cnt   <= 2'd0;
      r_hold  <= sh_block_in;
    end else if (w_out_hs) begin
      if (w_last_word) begin
        r_state <= IDLE;
        r_cnt   <= 2'd0;
        r_hold  <= '0;
      end else begin
        r_cnt   <= r_cnt + 2'd1;
      end
    end
  end

endmodule
